// File: rtl/io_bus_pkg.sv
// Shared types and constants for the I/O page bus controller:
// FSM states, slot-map field layout and status register bit positions.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ERR_ACK = 2'd2
  } state_e;

  // Slot-map entry: [7:2] base word index, [1:0] log2 of slot size in words.
  localparam int MAP_ENTRY_W = 8;
  localparam int MAP_BASE_W  = 6;
  localparam int MAP_SZ_W    = 2;

  localparam logic [15:0] IO_PAGE = 16'hFFFF;

  localparam int STAT_TMO_BIT   = 31;
  localparam int STAT_UNMAP_BIT = 30;
  localparam int STAT_CNT_MSB   = 29;
  localparam int STAT_CNT_LSB   = 24;
  localparam int STAT_ADDR_MSB  = 23;
  localparam int STAT_ADDR_LSB  = 2;

  localparam int          ERR_CNT_W   = 6;
  localparam logic [5:0]  ERR_CNT_MAX = 6'd63;

  function automatic logic [31:0] pack_status(input logic        tmo,
                                              input logic        unmap,
                                              input logic [5:0]  cnt,
                                              input logic [21:0] addr);
    logic [31:0] status;
    status = '0;
    status[STAT_TMO_BIT]                  = tmo;
    status[STAT_UNMAP_BIT]                = unmap;
    status[STAT_CNT_MSB:STAT_CNT_LSB]     = cnt;
    status[STAT_ADDR_MSB:STAT_ADDR_LSB]   = addr;
    return status;
  endfunction

endpackage

// File: rtl/io_slot_dec.sv
// Address decoder for one I/O slot: a power-of-two sized, size-aligned
// window of word indices inside the I/O page.
module io_slot_dec
  import io_bus_pkg::*;
(
  input  logic                   i_sel,
  input  logic [MAP_BASE_W-1:0]  i_word,
  input  logic [MAP_ENTRY_W-1:0] i_map,
  output logic                   o_hit
);

  logic [MAP_BASE_W-1:0] w_base;
  logic [MAP_SZ_W-1:0]   w_sz;

  assign w_base = i_map[MAP_ENTRY_W-1 -: MAP_BASE_W];
  assign w_sz   = i_map[MAP_SZ_W-1:0];

  // Dropping the low sz bits on both sides aligns the window to its size.
  assign o_hit = i_sel && ((i_word >> w_sz) == (w_base >> w_sz));

endmodule

// File: rtl/io_bus_ctrl.sv
// I/O page controller: routes CPU accesses to device slots, answers the
// status register, and acks unmapped or timed-out accesses with an error.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int                                 NUM_SLOTS  = 16,
  parameter logic [NUM_SLOTS*MAP_ENTRY_W-1:0]   SLOT_MAP   = '0,
  parameter int                                 TMO_CYCLES = 1023,
  parameter logic [MAP_BASE_W-1:0]              STAT_IDX   = 6'd10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_stb,
  input  logic                      bus_we,
  input  logic [23:2]               bus_addr,
  input  logic [31:0]               bus_dout,
  output logic                      io_sel,
  output logic [31:0]               io_din,
  output logic                      io_ack,
  output logic [NUM_SLOTS-1:0]      dev_stb,
  input  logic [NUM_SLOTS*32-1:0]   dev_dout,
  input  logic [NUM_SLOTS-1:0]      dev_ack,
  output logic                      err_trig
);

  localparam int               TMO_W    = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [TMO_W-1:0]        r_tmo_cnt;
  logic [TMO_W-1:0]        w_tmo_cnt_nxt;
  logic                    r_tmo;
  logic                    r_unmap;
  logic [ERR_CNT_W-1:0]    r_err_cnt;
  logic [21:0]             r_last_addr;
  logic                    r_err_trig;

  logic [MAP_BASE_W-1:0]   w_word;
  logic                    w_stat_hit;
  logic                    w_slot_sel;
  logic [NUM_SLOTS-1:0]    w_hit;
  logic [NUM_SLOTS-1:0]    w_win;
  logic                    w_slot_any;
  logic                    w_dev_ack;
  logic [31:0]             w_dev_rdata;
  logic                    w_unmap;
  logic                    w_unmap_evt;
  logic                    w_tmo_evt;
  logic                    w_err_evt;
  logic                    w_stat_clr;
  logic [31:0]             w_stat_word;
  logic                    w_unused;

  assign io_sel     = bus_stb && (bus_addr[23:8] == IO_PAGE);
  assign w_word     = bus_addr[7:2];
  assign w_stat_hit = io_sel && (w_word == STAT_IDX);
  assign w_slot_sel = io_sel && !w_stat_hit;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    io_slot_dec u_dec (
      .i_sel  (w_slot_sel),
      .i_word (w_word),
      .i_map  (SLOT_MAP[gi*MAP_ENTRY_W +: MAP_ENTRY_W]),
      .o_hit  (w_hit[gi])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic found;
    found       = 1'b0;
    w_win       = '0;
    w_dev_ack   = 1'b0;
    w_dev_rdata = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_hit[i] && !found) begin
        found       = 1'b1;
        w_win[i]    = 1'b1;
        w_dev_ack   = dev_ack[i];
        w_dev_rdata = dev_dout[i*32 +: 32];
      end
    end
  end

  assign w_slot_any  = |w_win;
  assign w_unmap     = w_slot_sel && !w_slot_any;
  assign w_unmap_evt = w_unmap && (r_state != ST_ERR_ACK);
  assign w_tmo_evt   = (r_state == ST_WAIT) && (w_state_nxt == ST_ERR_ACK);
  assign w_err_evt   = w_unmap_evt || w_tmo_evt;
  assign w_stat_clr  = w_stat_hit && bus_we && (r_state != ST_ERR_ACK);
  assign w_stat_word = pack_status(r_tmo, r_unmap, r_err_cnt, r_last_addr);

  // A status write clears the flags whatever the data, so bus_dout has no consumer.
  assign w_unused = ^bus_dout;

  always_comb begin
    w_state_nxt   = r_state;
    w_tmo_cnt_nxt = r_tmo_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_slot_any && !w_dev_ack) begin
          w_state_nxt   = ST_WAIT;
          w_tmo_cnt_nxt = TMO_ONE;
        end
      end
      ST_WAIT: begin
        if (!bus_stb || w_dev_ack) begin
          w_state_nxt = ST_IDLE;
        end else if (!io_sel) begin
          w_state_nxt = ST_WAIT;
        end else if (!w_slot_any) begin
          // The CPU moved to the status register or an unmapped word; those complete on their own.
          w_state_nxt = ST_IDLE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt = ST_ERR_ACK;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_ONE;
        end
      end
      ST_ERR_ACK: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    io_ack  = 1'b0;
    io_din  = '0;
    dev_stb = '0;
    if (r_state == ST_ERR_ACK) begin
      io_ack = 1'b1;
    end else if (w_stat_hit) begin
      io_ack = 1'b1;
      io_din = bus_we ? 32'd0 : w_stat_word;
    end else if (w_slot_any) begin
      dev_stb = w_win;
      io_ack  = w_dev_ack;
      io_din  = w_dev_rdata;
    end else if (w_unmap) begin
      io_ack = 1'b1;
    end
  end

  assign err_trig = r_err_trig;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_tmo       <= 1'b0;
      r_unmap     <= 1'b0;
      r_err_cnt   <= '0;
      r_last_addr <= '0;
      r_err_trig  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_err_trig <= w_err_evt;
      if (w_stat_clr) begin
        r_tmo     <= 1'b0;
        r_unmap   <= 1'b0;
        r_err_cnt <= '0;
      end else begin
        if (w_tmo_evt)   r_tmo   <= 1'b1;
        if (w_unmap_evt) r_unmap <= 1'b1;
        if (w_err_evt) begin
          if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + 6'd1;
          r_last_addr <= bus_addr;
        end
      end
    end
  end

endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, default 16, number of I/O device slots (1..32).
REQ-002 Parameter SLOT_MAP, default all-zero, NUM_SLOTS*8 bits; entry i = bits [8i+7:8i], where [7:2] is the base word index in the I/O page and [1:0] is log2 of the slot size in words.
REQ-003 Parameter TMO_CYCLES, default 1023, number of wait cycles before a bus timeout.
REQ-004 Parameter STAT_IDX, default 6'd10, word index of the internal status register (-216).
REQ-005 Single clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 bus_stb  in  1  CPU access strobe.
REQ-009 bus_we  in  1  CPU write enable.
REQ-010 bus_addr  in  22 [23:2]  CPU word address.
REQ-011 bus_dout  in  32  CPU write data.
REQ-012 io_sel  out  1  access targets the I/O page; the top level selects this block's data and ack.
REQ-013 io_din  out  32  read data to the CPU.
REQ-014 io_ack  out  1  access completion to the CPU.
REQ-015 dev_stb  out  NUM_SLOTS  per-slot device strobe.
REQ-016 dev_dout  in  NUM_SLOTS*32  per-slot device read data.
REQ-017 dev_ack  in  NUM_SLOTS  per-slot device ack.
REQ-018 err_trig  out  1  error pulse, wired to a sysctrl err_sig_in bit.

Function
REQ-019 io_sel SHALL be 1 iff bus_stb=1 and bus_addr[23:8]=16'hFFFF (combinational).
REQ-020 Slot i SHALL hit iff io_sel=1 and (bus_addr[7:2]>>sz_i)==(base_i>>sz_i); on overlap the lowest index wins; the status register has priority over all slots.
REQ-021 dev_stb[i] SHALL be 1 for the winning slot only, and only in state IDLE or WAIT.
REQ-022 In a slot access, io_din SHALL equal the winning slot's dev_dout and io_ack SHALL equal its dev_ack, combinationally, with zero added latency.
REQ-023 A status register read SHALL ack in the same cycle: io_din={tmo,unmap,cnt[5:0],last_addr[23:2],2'b00}.
REQ-024 A status register write SHALL ack in the same cycle, clear tmo, unmap and cnt, and leave last_addr unchanged.
REQ-025 FSM states: IDLE, WAIT, ERR_ACK.
REQ-026 FSM IDLE->WAIT: slot hit with dev_ack=0; timeout counter loads 1.
REQ-027 FSM WAIT->IDLE: dev_ack=1, or bus_stb drops.
REQ-028 FSM WAIT->ERR_ACK: counter equals TMO_CYCLES with dev_ack still 0.
REQ-029 FSM ERR_ACK->IDLE: unconditional.
REQ-030 In ERR_ACK: io_ack=1, io_din=0, dev_stb=0 and err_trig=1 for exactly one cycle; tmo is set, cnt increments and last_addr captures bus_addr.
REQ-031 An unmapped I/O address (no slot, not status) SHALL get io_ack=1 and io_din=0 in the same cycle.
REQ-032 On an unmapped access, err_trig=1, unmap is set, cnt increments and last_addr is captured, all on the next clock edge, exactly once per access.
REQ-033 cnt SHALL saturate at 63 and never wrap.
REQ-034 The timeout counter SHALL be $clog2(TMO_CYCLES+1) bits wide, reload on every new access, and never wrap.
REQ-035 A non-I/O access SHALL leave io_ack=0, io_din=0, dev_stb=0 and the state unchanged.

Reset
REQ-036 On rst: state=IDLE, counter=0, tmo=0, unmap=0, cnt=0, last_addr=0, err_trig=0.
REQ-037 rst asserted mid-WAIT SHALL abort the access with no ack and no err_trig.
REQ-038 All outputs SHALL be 0 in the cycle after rst while bus_stb=0.

Structure
REQ-039 Package io_bus_pkg SHALL hold:
- the state enum;
- the slot-map field widths;
- the status bit positions (tmo=31, unmap=30, cnt=29:24, addr=23:2).
REQ-040 One sub-module, io_slot_dec, SHALL be instantiated per slot; it performs the base/size compare.

Verification
REQ-041 Slot 3 mapped at {6'd52,2'd1} (-48/-44); read at -44 with dev_ack=1 same cycle and dev_dout=32'hA5 -> io_ack=1 same cycle, io_din=32'hA5, no err_trig.
REQ-042 TMO_CYCLES=8 and slot 0 never acks -> ERR_ACK on cycle 9; io_ack=1, io_din=0, err_trig one cycle; status read gives tmo=1, cnt=1, last_addr=0xFFFFC0>>2.
REQ-043 Read at unmapped -252 -> io_ack=1 same cycle, io_din=0, err_trig next cycle; status shows unmap=1.
REQ-044 70 unmapped accesses -> cnt=63; write 0 to status -> tmo=unmap=cnt=0, last_addr retained.
REQ-045 rst asserted on WAIT cycle 3 -> state IDLE, no io_ack, no err_trig, all flags 0.
REQ-046 Slots 0 and 1 both mapping -64 -> only dev_stb[0]=1.
